// File: rtl/pipe_ctrl_regs.sv
// Pipeline control registers for a 5-stage MIPS-style core: fetch PC, IF/ID,
// ID/EX, EX/MEM and MEM/WB control state, with stall, flush and bubble handling.
// Optional feature: define PIPE_STATS_EN to add stall/flush/retire counters.
module pipe_ctrl_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic [31:0] PCNextF,
  input  logic [31:0] InstrF,
  input  logic [5:0]  CtrlD,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        ValidE,
  output logic        ValidM,
  output logic        ValidW,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  RdE,
  output logic [4:0]  WriteRegE,
  output logic [4:0]  WriteRegM,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteE,
  output logic        RegWriteM,
  output logic        RegWriteW,
  output logic        MemtoRegE,
  output logic        MemtoRegM,
  output logic        MemWriteE,
  output logic        MemWriteM,
  output logic        ALUSrcE
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount,
  output logic [31:0] RetireCount
`endif
);

  // CtrlD = {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, Branch}
  logic [31:0] r_pcf;
  logic [31:0] r_instr_d;
  logic [31:0] r_pcplus4_d;
  logic        r_valid_d;

  logic [4:0]  r_rs_e, r_rt_e, r_rd_e;
  logic        r_regwrite_e, r_memtoreg_e, r_memwrite_e, r_alusrc_e, r_regdst_e;
  logic        r_valid_e;

  logic [4:0]  r_writereg_m;
  logic        r_regwrite_m, r_memtoreg_m, r_memwrite_m, r_valid_m;

  logic [4:0]  r_writereg_w;
  logic        r_regwrite_w, r_valid_w;

  logic [4:0]  w_writereg_e;
  // Branch is resolved upstream; it has no E-stage consumer here.
  logic        w_unused_branch;

  assign w_unused_branch = CtrlD[0];
  assign w_writereg_e    = r_regdst_e ? r_rd_e : r_rt_e;

  // Fetch PC: advances unless fetch is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcf <= 32'h0000_0000;
    end else if (!StallF) begin
      r_pcf <= PCNextF;
    end
  end

  // IF/ID: a stall holds D even when a flush is requested in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_d   <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (!StallD) begin
      if (FlushD) begin
        r_instr_d   <= '0;
        r_pcplus4_d <= '0;
        r_valid_d   <= 1'b0;
      end else begin
        r_instr_d   <= InstrF;
        r_pcplus4_d <= r_pcf + 32'd4;
        r_valid_d   <= 1'b1;
      end
    end
  end

  // ID/EX: reloads every cycle; a flush or an invalid D slot becomes a full bubble.
  always_ff @(posedge clk) begin
    if (reset || FlushE || !r_valid_d) begin
      r_rs_e       <= '0;
      r_rt_e       <= '0;
      r_rd_e       <= '0;
      r_regwrite_e <= 1'b0;
      r_memtoreg_e <= 1'b0;
      r_memwrite_e <= 1'b0;
      r_alusrc_e   <= 1'b0;
      r_regdst_e   <= 1'b0;
      r_valid_e    <= 1'b0;
    end else begin
      r_rs_e       <= r_instr_d[25:21];
      r_rt_e       <= r_instr_d[20:16];
      r_rd_e       <= r_instr_d[15:11];
      r_regwrite_e <= CtrlD[5];
      r_memtoreg_e <= CtrlD[4];
      r_memwrite_e <= CtrlD[3];
      r_alusrc_e   <= CtrlD[2];
      r_regdst_e   <= CtrlD[1];
      r_valid_e    <= 1'b1;
    end
  end

  // EX/MEM and MEM/WB: advance unconditionally; there is no back-end stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_writereg_m <= '0;
      r_regwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_memwrite_m <= 1'b0;
      r_valid_m    <= 1'b0;
      r_writereg_w <= '0;
      r_regwrite_w <= 1'b0;
      r_valid_w    <= 1'b0;
    end else begin
      r_writereg_m <= w_writereg_e;
      r_regwrite_m <= r_regwrite_e;
      r_memtoreg_m <= r_memtoreg_e;
      r_memwrite_m <= r_memwrite_e;
      r_valid_m    <= r_valid_e;
      r_writereg_w <= r_writereg_m;
      r_regwrite_w <= r_regwrite_m;
      r_valid_w    <= r_valid_m;
    end
  end

  assign PCF       = r_pcf;
  assign InstrD    = r_instr_d;
  assign PCPlus4D  = r_pcplus4_d;
  assign ValidD    = r_valid_d;
  assign ValidE    = r_valid_e;
  assign ValidM    = r_valid_m;
  assign ValidW    = r_valid_w;
  assign RsE       = r_rs_e;
  assign RtE       = r_rt_e;
  assign RdE       = r_rd_e;
  assign WriteRegE = w_writereg_e;
  assign WriteRegM = r_writereg_m;
  assign WriteRegW = r_writereg_w;
  // Write enables are qualified by Valid so a bubble can never write.
  assign RegWriteE = r_regwrite_e & r_valid_e;
  assign RegWriteM = r_regwrite_m & r_valid_m;
  assign RegWriteW = r_regwrite_w & r_valid_w;
  assign MemWriteE = r_memwrite_e & r_valid_e;
  assign MemWriteM = r_memwrite_m & r_valid_m;
  assign MemtoRegE = r_memtoreg_e;
  assign MemtoRegM = r_memtoreg_m;
  assign ALUSrcE   = r_alusrc_e;

`ifdef PIPE_STATS_EN
  logic [31:0] r_stall_cnt, r_flush_cnt, r_retire_cnt;

  // Event counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (StallD)          r_stall_cnt  <= r_stall_cnt + 32'd1;
      if (FlushD || FlushE) r_flush_cnt <= r_flush_cnt + 32'd1;
      if (r_valid_w)       r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign StallCount  = r_stall_cnt;
  assign FlushCount  = r_flush_cnt;
  assign RetireCount = r_retire_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Self-checking bench for pipe_ctrl_regs: table-driven streaming with a W-stage
// scoreboard, plus hand-written stall/flush/reset sequences.
// Build with PIPE_STATS_EN defined to also check the statistics counters.
module tb_pipe_ctrl_regs;

  logic        clk, reset, StallF, StallD, FlushD, FlushE;
  logic [31:0] PCNextF, InstrF;
  logic [5:0]  CtrlD;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic        ValidD, ValidE, ValidM, ValidW;
  logic [4:0]  RsE, RtE, RdE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic        MemWriteE, MemWriteM, ALUSrcE;
`ifdef PIPE_STATS_EN
  logic [31:0] StallCount, FlushCount, RetireCount;
`endif

  pipe_ctrl_regs dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .PCNextF(PCNextF), .InstrF(InstrF), .CtrlD(CtrlD),
    .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW),
    .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .MemWriteE(MemWriteE), .MemWriteM(MemWriteM), .ALUSrcE(ALUSrcE)
`ifdef PIPE_STATS_EN
    ,
    .StallCount(StallCount), .FlushCount(FlushCount), .RetireCount(RetireCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  ctrl;
    logic [4:0]  rs, rt, rd, wreg;
    logic        rw, mw;
  } vec_t;

  typedef struct {
    logic [4:0] wreg;
    logic       rw;
  } sb_t;

  vec_t vecs[6];
  sb_t  sb_q[$];
  bit   sb_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int unsigned exp_stall = 0, exp_flush = 0, exp_retire = 0;
  logic [31:0] exp_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock edge; expected counter values follow the inputs presented at the edge.
  task automatic tick();
    if (reset) begin
      exp_stall = 0; exp_flush = 0; exp_retire = 0;
    end else begin
      if (StallD) exp_stall++;
      if (FlushD || FlushE) exp_flush++;
      if (ValidW) exp_retire++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
    PCNextF = 32'd4; InstrF = '0; CtrlD = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  // W-stage scoreboard: every retiring instruction must match the next queued entry.
  always @(negedge clk) begin
    if (sb_en) begin
      if (ValidW) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_retire", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("sb_WriteRegW", {27'd0, WriteRegW}, {27'd0, e.wreg});
          check("sb_RegWriteW", {31'd0, RegWriteW}, {31'd0, e.rw});
        end
      end else begin
        check("sb_bubble_RegWriteW", {31'd0, RegWriteW}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //            instr          ctrl       rs  rt  rd  wreg rw mw
    vecs[0] = '{32'h20010005, 6'b100100, 5'd0, 5'd1, 5'd0, 5'd1, 1'b1, 1'b0}; // addi $1
    vecs[1] = '{32'h20020007, 6'b100100, 5'd0, 5'd2, 5'd0, 5'd2, 1'b1, 1'b0}; // addi $2
    vecs[2] = '{32'h00221820, 6'b100010, 5'd1, 5'd2, 5'd3, 5'd3, 1'b1, 1'b0}; // add $3
    vecs[3] = '{32'h8C430000, 6'b110100, 5'd2, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0}; // lw $3
    vecs[4] = '{32'hAC250004, 6'b001100, 5'd1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1}; // sw $5
    vecs[5] = '{32'h10220003, 6'b000001, 5'd1, 5'd2, 5'd0, 5'd2, 1'b0, 1'b0}; // beq

    reset = 1;
    idle_inputs();
    StallF = 1; FlushD = 1;
    tick();
    tick();
    check("rst_PCF", PCF, 32'h0);
    check("rst_InstrD", InstrD, 32'h0);
    check("rst_PCPlus4D", PCPlus4D, 32'h0);
    check("rst_valids", {28'd0, ValidD, ValidE, ValidM, ValidW}, 32'h0);
    check("rst_writes", {27'd0, RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM}, 32'h0);
    check("rst_WriteRegW", {27'd0, WriteRegW}, 32'h0);
    idle_inputs();
    reset = 0;

    // Streaming table: one instruction per cycle, no stalls.
    exp_pc = 32'h0;
    sb_en  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("stream_PCF", PCF, exp_pc);
      InstrF  = vecs[i].instr;
      CtrlD   = (i > 0) ? vecs[i-1].ctrl : 6'b0;
      PCNextF = exp_pc + 32'd4;
      sb_q.push_back('{wreg: vecs[i].wreg, rw: vecs[i].rw});
      tick();
      exp_pc = exp_pc + 32'd4;
      check("stream_InstrD", InstrD, vecs[i].instr);
      check("stream_PCPlus4D", PCPlus4D, exp_pc);
      check("stream_ValidD", {31'd0, ValidD}, 32'd1);
      if (i >= 1) begin
        check("stream_RsE", {27'd0, RsE}, {27'd0, vecs[i-1].rs});
        check("stream_RtE", {27'd0, RtE}, {27'd0, vecs[i-1].rt});
        check("stream_RdE", {27'd0, RdE}, {27'd0, vecs[i-1].rd});
        check("stream_WriteRegE", {27'd0, WriteRegE}, {27'd0, vecs[i-1].wreg});
        check("stream_RegWriteE", {31'd0, RegWriteE}, {31'd0, vecs[i-1].rw});
        check("stream_MemWriteE", {31'd0, MemWriteE}, {31'd0, vecs[i-1].mw});
      end
      if (i == 3) begin
        check("lat4_ValidW", {31'd0, ValidW}, 32'd1);
        check("lat4_WriteRegW", {27'd0, WriteRegW}, 32'd1);
        check("lat4_RegWriteW", {31'd0, RegWriteW}, 32'd1);
      end
    end
    // Drain: bubble D and let the last instructions reach W.
    CtrlD = vecs[5].ctrl; FlushD = 1; StallF = 1;
    tick();
    CtrlD = '0;
    for (int k = 0; k < 3; k++) tick();
    check("sb_drained", sb_q.size(), 32'd0);
    sb_en = 1'b0;

    // Load in E, then StallF+StallD+FlushE for one cycle.
    do_reset();
    InstrF = 32'h8C430000; PCNextF = 32'd4;
    tick();
    InstrF = 32'h20010005; CtrlD = 6'b110100; PCNextF = 32'd8;
    tick();
    check("ld_E_MemtoRegE", {31'd0, MemtoRegE}, 32'd1);
    check("ld_E_WriteRegE", {27'd0, WriteRegE}, 32'd3);
    check("ld_E_ALUSrcE", {31'd0, ALUSrcE}, 32'd1);
    StallF = 1; StallD = 1; FlushE = 1;
    InstrF = 32'h20020007; CtrlD = 6'b100100; PCNextF = 32'd12;
    tick();
    check("stl_PCF_hold", PCF, 32'd8);
    check("stl_InstrD_hold", InstrD, 32'h20010005);
    check("stl_ValidE", {31'd0, ValidE}, 32'd0);
    check("stl_RegWriteE", {31'd0, RegWriteE}, 32'd0);
    check("stl_ValidM", {31'd0, ValidM}, 32'd1);
    check("stl_MemtoRegM", {31'd0, MemtoRegM}, 32'd1);
    check("stl_WriteRegM", {27'd0, WriteRegM}, 32'd3);
    StallF = 0; StallD = 0; FlushE = 0;
    tick();
    check("ld_W_RegWriteW", {31'd0, RegWriteW}, 32'd1);
    check("ld_W_WriteRegW", {27'd0, WriteRegW}, 32'd3);

    // FlushD with a load in fetch: D becomes a bubble and nothing writes back.
    do_reset();
    InstrF = 32'h8C430000; CtrlD = 6'b110100; FlushD = 1;
    tick();
    check("fd_InstrD", InstrD, 32'h0);
    check("fd_ValidD", {31'd0, ValidD}, 32'd0);
    check("fd_PCPlus4D", PCPlus4D, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fd_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    end

    // StallD has priority over FlushD.
    FlushD = 0; InstrF = 32'h00221820;
    tick();
    StallD = 1; FlushD = 1; InstrF = 32'hFFFFFFFF;
    tick();
    check("sd_fd_InstrD", InstrD, 32'h00221820);
    check("sd_fd_ValidD", {31'd0, ValidD}, 32'd1);

    // Reset mid-stream with three instructions in flight.
    do_reset();
    InstrF = 32'h20010005; CtrlD = 6'b100100;
    for (int k = 0; k < 3; k++) begin
      PCNextF = PCF + 32'd4;
      tick();
    end
    check("fly_valids", {29'd0, ValidD, ValidE, ValidM}, 32'h7);
    reset = 1; StallF = 1; StallD = 1; FlushE = 1;
    tick();
    check("mid_rst_PCF", PCF, 32'h0);
    check("mid_rst_valids", {28'd0, ValidD, ValidE, ValidM, ValidW}, 32'h0);
    check("mid_rst_RegWriteM", {31'd0, RegWriteM}, 32'd0);
    reset = 0; StallF = 0; StallD = 0; FlushE = 0;
    InstrF = 32'hABCD0123; PCNextF = 32'd4;
    tick();
    check("post_rst_PCF", PCF, 32'd4);
    check("post_rst_PCPlus4D", PCPlus4D, 32'd4);

    // StallF without StallD: D re-fetches from the held PC.
    StallF = 1; InstrF = 32'h12345678; PCNextF = 32'd100;
    tick();
    check("sf_PCF_hold", PCF, 32'd4);
    check("sf_InstrD", InstrD, 32'h12345678);
    check("sf_PCPlus4D", PCPlus4D, 32'd8);

    // Statistics: 3 stall cycles and 2 flush cycles after a reset.
    do_reset();
    InstrF = 32'h20010005; CtrlD = 6'b100100;
    for (int k = 0; k < 12; k++) begin
      StallD = (k >= 2 && k <= 4);
      FlushD = (k == 6);
      FlushE = (k == 6 || k == 8);
      PCNextF = PCF + 32'd4;
      tick();
    end
    idle_inputs();
    StallF = 1;
`ifdef PIPE_STATS_EN
    check("st_StallCount", StallCount, 32'd3);
    check("st_FlushCount", FlushCount, 32'd2);
    check("st_RetireCount", RetireCount, exp_retire);
    check("st_stall_model", exp_stall, 32'd3);
    check("st_flush_model", exp_flush, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_regs.md
PIPE_CTRL_REGS -- requirements
Module: pipe_ctrl_regs

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The port list SHALL be as follows, clock and reset first.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hold PCF
- StallD  in  1  hold D stage
- FlushD  in  1  branch taken; bubble D
- FlushE  in  1  bubble E
- PCNextF  in  32  next fetch address
- InstrF  in  32  fetched instruction
- CtrlD  in  6  {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, Branch}
- PCF  out  32  fetch PC
- InstrD  out  32  D-stage instruction
- PCPlus4D  out  32  PCF+4, registered
- ValidD/E/M/W  out  1 each  stage holds a real instruction
- RsE, RtE, RdE  out  5 each  E-stage register indices
- WriteRegE/M/W  out  5 each  destination register per stage
- RegWriteE/M/W  out  1 each  gated write enable
- MemtoRegE/M  out  1 each  load flag
- MemWriteE/M  out  1 each  store flag
- ALUSrcE  out  1  E-stage ALU operand select

Function
REQ-003 PCF SHALL load PCNextF each cycle unless StallF=1.
REQ-004 The IF/ID register SHALL load InstrF, PCF+4 (modulo 2^32) and ValidD=1 unless StallD=1.
REQ-005 FlushD=1 with StallD=0 SHALL load InstrD=0, ValidD=0 and SHALL clear PCPlus4D to 0.
REQ-006 StallD=1 SHALL take priority over FlushD (D held).
REQ-007 The ID/EX register SHALL load RsD=InstrD[25:21], RtD=InstrD[20:16], RdD=InstrD[15:11] and CtrlD every cycle.
REQ-008 WriteRegE SHALL equal RdE if RegDstE=1, else RtE, combinationally from E-stage state.
REQ-009 FlushE=1 SHALL zero all E-stage control bits and indices and clear ValidE, regardless of StallD.
REQ-010 An E bubble SHALL be inserted whenever ValidD=0 (RegWriteE, MemWriteE=0).
REQ-011 E->M and M->W SHALL advance unconditionally every cycle; there is no M/W stall.
REQ-012 RegWriteX and MemWriteX outputs SHALL be ANDed with ValidX, so no write ever issues from a bubble.
REQ-013 Latency InstrF to W-stage indices SHALL be 4 cycles with no stall or flush.
REQ-014 StallF=1 with StallD=0 SHALL be legal; D loads InstrF of the held PCF again.
REQ-015 Simultaneous StallD=1 and FlushE=1 SHALL hold D and bubble E in the same edge.

Reset
REQ-016 reset=1 at a clock edge SHALL set PCF=0x00000000, and every other output register and every Valid bit to 0; reset SHALL override stall and flush.
REQ-017 Reset asserted mid-stream SHALL discard all in-flight instructions; the first fetch after reset deassertion SHALL be at PC 0.

Configuration
REQ-018 With macro PIPE_STATS_EN defined, the block SHALL add outputs StallCount[31:0], FlushCount[31:0] and RetireCount[31:0].
- StallCount SHALL increment on cycles with StallD=1.
- FlushCount SHALL increment on cycles with FlushD=1 or FlushE=1; each such cycle counts once.
- RetireCount SHALL increment on cycles with ValidW=1.
- All three counters SHALL wrap at 2^32 and be cleared by reset.
REQ-019 Without PIPE_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-020 Reset, then sequential InstrF 0x20010005, 0x20020007 with no stalls -> PCF steps 0,4,8; WriteRegW=1 with RegWriteW=1 in cycle 4.
REQ-021 Load in E plus StallF=StallD=FlushE=1 for one cycle -> PCF and InstrD hold; ValidE=0 and RegWriteE=0 next cycle; the load continues to M.
REQ-022 FlushD=1 with InstrF=0x8C430000 -> InstrD=0, ValidD=0; nothing reaches W with RegWriteW=1.
REQ-023 StallD=1 and FlushD=1 together -> InstrD unchanged.
REQ-024 Reset asserted for 1 cycle with 3 valid instructions in flight -> all Valid=0 and PCF=0 at the next edge.
REQ-025 PIPE_STATS_EN defined, 3 stall cycles and 2 flush cycles -> StallCount=3, FlushCount=2; RetireCount equals the number of ValidW cycles.
